config_loader: RTL

Upstream configuration sequencer for the PE-tile array. Accepts a byte-wide configuration bitstream over a valid/ready stream, assembles 8-byte frames (32-bit address, 32-bit data), and drives the shared `config_addr`/`config_data` bus consumed by every tile's SB/CB/CLB decode. When idle, the bus holds an address that matches no tile, and the stream ends with a terminator frame.

---
 rtl/config_pkg.sv | 31 +++
 rtl/cfg_frame_shifter.sv | 41 ++++
 rtl/config_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the configuration loader and the PE tiles that decode its bus.
// Holds the loader state encoding, frame geometry and the tile select codes.
package config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int FRAME_BYTES = 8;
  localparam int WORD_BYTES  = 4;

  localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'hFFFF_FFFF;

  // Upper address half selects the tile block; lower half is the tile id.
  localparam logic [15:0] CONFIG_SB  = 16'd7;
  localparam logic [15:0] CONFIG_CB0 = 16'd6;
  localparam logic [15:0] CONFIG_CB1 = 16'd5;
  localparam logic [15:0] CONFIG_CLB = 16'd4;

  function automatic logic cfg_hit(input logic [31:0] addr, input logic [15:0] tile_id);
    logic sel_ok;
    sel_ok = (addr[31:16] == CONFIG_SB)  || (addr[31:16] == CONFIG_CB0) ||
             (addr[31:16] == CONFIG_CB1) || (addr[31:16] == CONFIG_CLB);
    return sel_ok && (addr[15:0] == tile_id);
  endfunction

endpackage

// File: rtl/cfg_frame_shifter.sv
// Byte-to-word assembler: shifts bytes MSB-first into a 32-bit word and flags the 4th byte.
// Reused for both the address and the data word of each frame.
module cfg_frame_shifter
  import config_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_done
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  idx_r;
  logic [31:0] word_r;

  // word_next is the completed word on the cycle word_done is high.
  assign word_next = {word_r[23:0], byte_in};
  assign word_done = load && (idx_r == LAST_IDX);

  // Byte index and shift register update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (clear) begin
      idx_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (load) begin
      idx_r  <= idx_r + 2'd1;
      word_r <= word_next;
    end else begin
      idx_r  <= idx_r;
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Configuration sequencer: assembles 8-byte address/data frames from a byte stream and
// drives the shared config bus, idling on IDLE_ADDR and stopping at the terminator frame.
module config_loader
  import config_pkg::*;
#(
  parameter int          HOLD_CYCLES = 1,
  parameter logic [31:0] IDLE_ADDR   = DEFAULT_IDLE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] write_count
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  hold_cnt_r;
  logic [31:0] addr_r;
  logic        xfer_s;
  logic        start_ok_s;
  logic        word_done_s;
  logic [31:0] word_next_s;

  assign xfer_s     = in_valid && in_ready;
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  cfg_frame_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok_s),
    .load      (xfer_s),
    .byte_in   (in_data),
    .word_next (word_next_s),
    .word_done (word_done_s)
  );

  // Frame sequencing FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      hold_cnt_r  <= 4'd0;
      addr_r      <= 32'd0;
      config_addr <= IDLE_ADDR;
      config_data <= 32'd0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      write_count <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            state_r     <= ST_ADDR;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            write_count <= 16'd0;
          end
        end
        ST_ADDR: begin
          if (word_done_s) begin
            addr_r  <= word_next_s;
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The terminator is recognised by address only; its data word is discarded.
          if (word_done_s) begin
            in_ready <= 1'b0;
            if (addr_r == IDLE_ADDR) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r     <= ST_WRITE;
              config_addr <= addr_r;
              config_data <= word_next_s;
              hold_cnt_r  <= HOLD_LAST;
              if (write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (hold_cnt_r == 4'd0) begin
            state_r     <= ST_ADDR;
            config_addr <= IDLE_ADDR;
            in_ready    <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          config_addr <= IDLE_ADDR;
          in_ready    <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
